// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: one outstanding req/ack bus transaction, pipeline stalled until it completes.
// Optional bus timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        control_m_i,
  input  logic [DATA_W-1:0] alu_out_m_i,
  input  logic [DATA_W-1:0] write_data_m_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] read_data_m_o,
  output logic              stall_m_o,
  output logic              mem_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_access;
  logic              w_timeout;
  logic              w_unused;

  assign w_access = control_m_i[1] | control_m_i[0];

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;

  // Fires on the BUSY cycle whose missing ack would bring the count to the limit.
  assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_BUSY) begin
        r_to_cnt <= '0;
      end else if (!mem_ack_i) begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
      r_err <= (r_state == S_BUSY) && !mem_ack_i && w_timeout;
    end
  end

  assign mem_err_o = r_err;
  assign w_unused  = ^{alu_out_m_i[1:0], control_m_i[2]};
`else
  assign w_timeout = 1'b0;
  assign mem_err_o = 1'b0;
  assign w_unused  = ^{alu_out_m_i[1:0], control_m_i[2], (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_m_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // No stall may be raised while the unit is held in reset.
        stall_m_o = w_access & rst_ni;
        if (w_access) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_m_o = 1'b1;
        if (mem_ack_i || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_req   <= 1'b1;
            r_we    <= control_m_i[0];
            r_addr  <= {alu_out_m_i[DATA_W-1:2], 2'b00};
            r_wdata <= write_data_m_i;
          end else begin
            r_req <= 1'b0;
          end
        end
        S_BUSY: begin
          // r_we doubles as the load/store flag of the transaction in flight.
          if (mem_ack_i) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_rdata <= mem_rdata_i;
            end
          end else if (w_timeout) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_rdata <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req_o     = r_req;
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign read_data_m_o = r_rdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage consumer of the execute-to-memory pipeline register outputs (control_m, alu_out_m, write_data_m). Turns load/store instructions into a single-outstanding req/ack transaction on the data-memory bus. Stalls the pipeline until the transaction completes, then presents load data for the writeback pipeline register.

Parameters:
DATA_W, 32, data and address width
TIMEOUT_CYCLES, 64, max BUSY cycles before abort (only with MEM_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
control_m_i  in  3  [2]=reg_write, [1]=mem_to_reg (load), [0]=mem_write (store)
alu_out_m_i  in  DATA_W  effective byte address
write_data_m_i  in  DATA_W  store data
mem_req_o  out  1  bus request, registered
mem_we_o  out  1  1=write, 0=read, registered
mem_addr_o  out  DATA_W  word-aligned address, registered
mem_wdata_o  out  DATA_W  store data, registered
mem_ack_i  in  1  bus completion; read data valid in the same cycle
mem_rdata_i  in  DATA_W  read data
read_data_m_o  out  DATA_W  captured load data, registered
stall_m_o  out  1  hold fetch/decode/execute/memory registers
mem_err_o  out  1  timeout abort pulse (0 when feature off)

Behaviour:
- access = control_m_i[1] | control_m_i[0]. If both bits are set, the store wins: mem_we_o=1 and no rdata capture.
- FSM states: IDLE, BUSY, DONE. Async reset forces IDLE.
- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, read_data_m_o=0, mem_err_o=0, state=IDLE.
- IDLE:
  - access=0: stall_m_o=0, bus outputs unchanged except mem_req_o=0.
  - access=1: stall_m_o=1 (combinational). On the clock edge: mem_req_o<=1, mem_we_o<=control_m_i[0], mem_addr_o<={alu_out_m_i[DATA_W-1:2],2'b00}, mem_wdata_o<=write_data_m_i; go to BUSY.
- BUSY:
  - stall_m_o=1; mem_req_o held at 1 and all bus outputs stable.
  - mem_ack_i=1: mem_req_o<=0; if load, read_data_m_o<=mem_rdata_i; go to DONE.
  - mem_ack_i=0: stay in BUSY.
- DONE:
  - stall_m_o=0 for exactly one cycle so the pipeline advances past the instruction; read_data_m_o is valid this cycle; go to IDLE unconditionally.
  - A following access is seen in IDLE on the next cycle, giving no back-to-back reissue of the same instruction.
- mem_ack_i is ignored in IDLE and DONE (spurious ack has no effect).
- read_data_m_o holds its value until the next load ack; stores do not modify it.
- Minimum load/store cost: 2 stall cycles (IDLE detect, BUSY with ack), then DONE.
- Non-memory instructions: no stall, no bus activity.
- Reset asserted mid-transaction: mem_req_o drops asynchronously, state=IDLE, captured data is lost.
- Address bits [1:0] are discarded; no misalignment trap.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES:
  - mem_req_o<=0;
  - read_data_m_o<=0 for loads;
  - mem_err_o<=1 for the single DONE cycle;
  - go to DONE.
- Ack in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter, mem_err_o tied 0, BUSY waits indefinitely.

Test Plan:
- Load, ack on first BUSY cycle: control=3'b110, alu_out=32'h0000_1006, rdata=32'hCAFE_F00D -> mem_addr_o=32'h0000_1004, mem_we_o=0, stall high 2 cycles, DONE cycle read_data_m_o=32'hCAFE_F00D.
- Store, ack after 3 wait cycles: control=3'b001, write_data=32'h1234_5678 -> mem_we_o=1, mem_wdata_o=32'h1234_5678 stable for all 4 BUSY cycles, stall 5 cycles, read_data_m_o unchanged.
- Non-memory op: control=3'b100 -> stall_m_o=0, mem_req_o=0 throughout.
- Back-to-back loads to 0x10 and 0x20 -> two separate req pulses separated by DONE and IDLE, read_data_m_o=each rdata in turn.
- Reset pulled low during BUSY -> mem_req_o=0 and stall_m_o=0 immediately; after release, an idle op sees no request.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 BUSY cycles, mem_err_o=1 for 1 cycle, read_data_m_o=0.
